// File: rtl/cache_pmem_arbiter.sv
// cache_pmem_arbiter
// Shares the single physical-memory port between the instruction cache and
// the data cache. One transaction is in flight at a time; the owning cache
// drives memory combinationally and alone sees the completion strobe. On a
// simultaneous request the port that did not finish last wins, so two
// continuously requesting caches alternate. Every transaction is followed by
// one IDLE cycle so requesters can drop their strobes before re-arbitration.

module cache_pmem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,

  // instruction cache side
  input  logic                  i_read,
  input  logic                  i_write,
  input  logic [ADDR_WIDTH-1:0] i_address,
  input  logic [LINE_WIDTH-1:0] i_wdata,
  output logic                  i_resp,
  output logic [LINE_WIDTH-1:0] i_rdata,

  // data cache side
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic                  d_resp,
  output logic [LINE_WIDTH-1:0] d_rdata,

  // physical memory side
  input  logic                  pmem_resp,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_e;

  // Encoding of the last_served register.
  localparam logic LAST_I = 1'b0;
  localparam logic LAST_D = 1'b1;

  state_e state_q;
  state_e state_d;
  logic   last_served_q;
  logic   last_served_d;

  logic   i_req;
  logic   d_req;

  // A cache is requesting when it raises either strobe.
  always_comb begin
    i_req = i_read | i_write;
    d_req = d_read | d_write;
  end

  // Read data is broadcast; each cache qualifies it with its own resp.
  always_comb begin
    i_rdata = pmem_rdata;
    d_rdata = pmem_rdata;
  end

  // State and fairness registers; reset hands the first tie to the icache.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      last_served_q <= LAST_D;
    end else begin
      state_q       <= state_d;
      last_served_q <= last_served_d;
    end
  end

  // Arbitration, completion tracking and memory-port steering.
  always_comb begin
    state_d       = state_q;
    last_served_d = last_served_q;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    pmem_address  = {ADDR_WIDTH{1'b0}};
    pmem_wdata    = {LINE_WIDTH{1'b0}};
    i_resp        = 1'b0;
    d_resp        = 1'b0;

    case (state_q)
      IDLE: begin
        // A pmem_resp seen here is stray (e.g. left over from a reset in
        // the middle of a transaction) and is deliberately dropped.
        if (i_req && d_req) begin
          if (last_served_q == LAST_D) begin
            state_d = SERVE_I;
          end else begin
            state_d = SERVE_D;
          end
        end else if (i_req) begin
          state_d = SERVE_I;
        end else if (d_req) begin
          state_d = SERVE_D;
        end else begin
          state_d = IDLE;
        end
      end

      SERVE_I: begin
        // Write has priority if the cache raises both strobes.
        pmem_write   = i_write;
        pmem_read    = i_read & ~i_write;
        pmem_address = i_address;
        pmem_wdata   = i_wdata;
        i_resp       = pmem_resp;
        // Stay here until memory answers, even if the icache drops its
        // request: the access has already been launched.
        if (pmem_resp) begin
          last_served_d = LAST_I;
          state_d       = IDLE;
        end else begin
          state_d       = SERVE_I;
        end
      end

      SERVE_D: begin
        pmem_write   = d_write;
        pmem_read    = d_read & ~d_write;
        pmem_address = d_address;
        pmem_wdata   = d_wdata;
        d_resp       = pmem_resp;
        if (pmem_resp) begin
          last_served_d = LAST_D;
          state_d       = IDLE;
        end else begin
          state_d       = SERVE_D;
        end
      end

      default: begin
        state_d       = IDLE;
        last_served_d = last_served_q;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_pmem_arbiter.sv
// Self-checking bench for cache_pmem_arbiter. A transaction-level reference
// (who owns the memory port, who finished last) predicts every output each
// cycle; a small latency-based memory model answers accesses, and the order
// in which the DUT actually puts each cache on the memory port is logged to
// check fairness.

module tb_cache_pmem_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_read, i_write, d_read, d_write;
  logic [15:0]  i_address, d_address;
  logic [255:0] i_wdata, d_wdata;
  logic         i_resp, d_resp;
  logic [255:0] i_rdata, d_rdata;
  logic         pmem_resp;
  logic [255:0] pmem_rdata;
  logic         pmem_read, pmem_write;
  logic [15:0]  pmem_address;
  logic [255:0] pmem_wdata;

  int errors = 0;
  int checks = 0;

  // reference: owner 0 = none, 1 = icache, 2 = dcache; last 1 = I, 2 = D
  int owner;
  int last_done;

  // memory model
  int mem_left;
  int lat;
  logic rand_lat;

  // requester behaviour after completion: 0 drop, 1 keep requesting, 2 random
  int i_mode, d_mode;
  logic i_done, d_done;

  logic prev_strobe;
  int grants[$];

  always #5 clk = ~clk;

  cache_pmem_arbiter #(.ADDR_WIDTH(16), .LINE_WIDTH(256)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_write(i_write), .i_address(i_address), .i_wdata(i_wdata),
    .i_resp(i_resp), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_resp(d_resp), .d_rdata(d_rdata),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata)
  );

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic new_i_req();
    int kind;
    kind      = $urandom_range(0, 3);
    i_read    = (kind != 1);
    i_write   = (kind == 1) || (kind == 3);
    i_address = {1'b0, 15'($urandom)};
    i_wdata   = rand_line();
  endtask

  task automatic new_d_req();
    int kind;
    kind      = $urandom_range(0, 3);
    d_read    = (kind != 1);
    d_write   = (kind == 1) || (kind == 3);
    d_address = {1'b1, 15'($urandom)};
    d_wdata   = rand_line();
  endtask

  // One clock cycle: check outputs at negedge, advance the reference and
  // memory at posedge, then update requesters.
  task automatic tick();
    logic         er, ew, eir, edr, ireq, dreq, strobe;
    logic [15:0]  ea;
    logic [255:0] ewd;
    int           nxt_owner, nxt_last;

    @(negedge clk);
    er = 1'b0; ew = 1'b0; eir = 1'b0; edr = 1'b0; ea = 16'h0000; ewd = '0;
    if (owner == 1) begin
      ew = i_write; er = i_read && !i_write; ea = i_address; ewd = i_wdata; eir = pmem_resp;
    end else if (owner == 2) begin
      ew = d_write; er = d_read && !d_write; ea = d_address; ewd = d_wdata; edr = pmem_resp;
    end
    check_eq("pmem_read", {255'd0, pmem_read}, {255'd0, er});
    check_eq("pmem_write", {255'd0, pmem_write}, {255'd0, ew});
    check_eq("pmem_address", {240'd0, pmem_address}, {240'd0, ea});
    check_eq("pmem_wdata", pmem_wdata, ewd);
    check_eq("i_resp", {255'd0, i_resp}, {255'd0, eir});
    check_eq("d_resp", {255'd0, d_resp}, {255'd0, edr});
    check_eq("i_rdata", i_rdata, pmem_rdata);
    check_eq("d_rdata", d_rdata, pmem_rdata);

    // record which cache the DUT actually put on the port
    strobe = pmem_read || pmem_write;
    if (strobe && !prev_strobe) grants.push_back((pmem_address == i_address) ? 1 : 2);
    prev_strobe = strobe;

    i_done = eir;
    d_done = edr;

    ireq = i_read || i_write;
    dreq = d_read || d_write;
    nxt_owner = owner;
    nxt_last  = last_done;
    if (rst) begin
      nxt_owner = 0;
      nxt_last  = 2;
    end else if (owner == 0) begin
      if (ireq && dreq) nxt_owner = (last_done == 1) ? 2 : 1;
      else if (ireq)    nxt_owner = 1;
      else if (dreq)    nxt_owner = 2;
    end else if (pmem_resp) begin
      nxt_last  = owner;
      nxt_owner = 0;
    end

    if ((er || ew) && mem_left == 0 && !pmem_resp) begin
      if (rand_lat) lat = $urandom_range(1, 4);
      mem_left = lat;
    end

    @(posedge clk);
    owner     = nxt_owner;
    last_done = nxt_last;
    #1;
    if (mem_left > 0) begin
      mem_left--;
      pmem_resp = (mem_left == 0);
    end else begin
      pmem_resp = 1'b0;
    end
    pmem_rdata = rand_line();

    if (i_done && i_mode != 1) begin i_read = 1'b0; i_write = 1'b0; end
    if (d_done && d_mode != 1) begin d_read = 1'b0; d_write = 1'b0; end
    if (i_mode == 2 && !i_read && !i_write && $urandom_range(0, 3) == 0) new_i_req();
    if (d_mode == 2 && !d_read && !d_write && $urandom_range(0, 3) == 0) new_d_req();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    rst = 1'b1;
    i_read = 1'b0; i_write = 1'b0; i_address = 16'h0000; i_wdata = '0;
    d_read = 1'b0; d_write = 1'b0; d_address = 16'h0000; d_wdata = '0;
    pmem_resp = 1'b0; pmem_rdata = '0;
    owner = 0; last_done = 2; mem_left = 0; lat = 3; rand_lat = 1'b0;
    i_mode = 0; d_mode = 0; i_done = 1'b0; d_done = 1'b0; prev_strobe = 1'b0;

    // reset state
    run(2);
    rst = 1'b0;
    run(1);

    // single icache read, latency 3
    i_read = 1'b1; i_address = 16'h0040;
    run(8);

    // single dcache writeback
    d_write = 1'b1; d_address = 16'h1200; d_wdata = {32{8'hA5}};
    run(8);

    // simultaneous requests right after reset: icache first
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    grants.delete();
    i_read = 1'b1; i_address = 16'h0100;
    d_read = 1'b1; d_address = 16'h2200;
    run(14);
    check_eq("tie_count", 256'(grants.size()), 256'd2);
    if (grants.size() >= 2) begin
      check_eq("tie_first", 256'(grants[0]), 256'd1);
      check_eq("tie_second", 256'(grants[1]), 256'd2);
    end

    // fairness under continuous contention
    grants.delete();
    i_mode = 1; d_mode = 1;
    i_read = 1'b1; i_address = 16'h0300;
    d_read = 1'b1; d_address = 16'h4400;
    for (int k = 0; k < 200 && grants.size() < 6; k++) tick();
    i_mode = 0; d_mode = 0;
    check_eq("fair_count", 256'(grants.size() >= 6), 256'd1);
    for (int k = 0; k < grants.size() && k < 6; k++)
      check_eq("fair_order", 256'(grants[k]), (k % 2 == 0) ? 256'd1 : 256'd2);
    for (int k = 0; k < 40 && (i_read || d_read); k++) tick();
    check_eq("fair_drain", {255'd0, i_read || d_read}, 256'd0);
    run(3);

    // reset in the middle of a dcache transaction; memory answers later
    lat = 4;
    d_read = 1'b1; d_address = 16'h5600;
    run(2);
    rst = 1'b1; d_read = 1'b0;
    run(1);
    rst = 1'b0;
    run(6);
    lat = 3;
    i_read = 1'b1; i_address = 16'h0780;
    run(8);

    // dcache raises both strobes: write wins
    d_read = 1'b1; d_write = 1'b1; d_address = 16'h1a00; d_wdata = rand_line();
    run(8);

    // randomized traffic with occasional resets
    rand_lat = 1'b1;
    i_mode = 2; d_mode = 2;
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 199) == 0) rst = 1'b1;
      tick();
      rst = 1'b0;
    end
    i_mode = 0; d_mode = 0;
    run(30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
